// File: rtl/osd_dii_arbiter_if.sv
// DII flit bundle between NUM_IN sources, the arbiter and the downstream ring router port.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface osd_dii_arbiter_if #(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 16
);
  logic [NUM_IN-1:0]             debug_in_valid;
  logic [NUM_IN-1:0]             debug_in_last;
  logic [NUM_IN-1:0][DATA_W-1:0] debug_in_data;
  logic [NUM_IN-1:0]             debug_in_ready;
  logic                          debug_out_valid;
  logic                          debug_out_last;
  logic [DATA_W-1:0]             debug_out_data;
  logic                          debug_out_ready;

  modport slave (
    input  debug_in_valid, debug_in_last, debug_in_data, debug_out_ready,
    output debug_in_ready, debug_out_valid, debug_out_last, debug_out_data
  );

  modport master (
    output debug_in_valid, debug_in_last, debug_in_data, debug_out_ready,
    input  debug_in_ready, debug_out_valid, debug_out_last, debug_out_data
  );
endinterface

// File: rtl/osd_dii_arbiter.sv
// Packet-atomic round-robin arbiter sharing one DII output between NUM_IN sources.
// Flit path is combinational; lock, pointer and length state are registered.
module osd_dii_arbiter #(
  parameter int NUM_IN      = 2,
  parameter int MAX_PKT_LEN = 12,
  localparam int SEL_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  osd_dii_arbiter_if.slave     dii,
  output logic                 grant_active,
  output logic [SEL_W-1:0]     grant_idx,
  output logic                 pkt_len_err
);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 2);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_p0, state_n;
  logic [SEL_W-1:0]   sel_p0, sel_n;
  logic [SEL_W-1:0]   ptr_p0, ptr_n;
  logic [CNT_W-1:0]   cnt_p0, cnt_n;
  logic               err_p0, err_n;
  logic               grant_active_p0;
  logic [SEL_W-1:0]   grant_idx_p0;

  logic               rr_found;
  logic [SEL_W-1:0]   rr_sel;
  logic [SEL_W-1:0]   cur_sel;
  logic               active;
  logic               xfer;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
    if (int'(s) >= NUM_IN - 1) return '0;
    return s + SEL_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (int'(c) >= MAX_PKT_LEN + 1) return c;
    return c + CNT_W'(1);
  endfunction

  // Search downward so the candidate closest to ptr (k = 0) wins.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = int'(ptr_p0) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (dii.debug_in_valid[SEL_W'(idx)]) begin
        rr_found = 1'b1;
        rr_sel   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    cur_sel             = (state_p0 == LOCKED) ? sel_p0 : rr_sel;
    active              = !rst && ((state_p0 == LOCKED) || rr_found);
    dii.debug_out_valid = active && dii.debug_in_valid[cur_sel];
    dii.debug_out_last  = dii.debug_in_last[cur_sel];
    dii.debug_out_data  = dii.debug_in_data[cur_sel];
    dii.debug_in_ready  = '0;
    if (active) dii.debug_in_ready[cur_sel] = dii.debug_out_ready;
    xfer = dii.debug_out_valid && dii.debug_out_ready;
  end

  // A stalled first flit also locks, so the presented flit cannot change under backpressure.
  always_comb begin
    state_n = state_p0;
    sel_n   = sel_p0;
    ptr_n   = ptr_p0;
    cnt_n   = cnt_p0;
    err_n   = err_p0;
    if (active) begin
      if (xfer && dii.debug_out_last) begin
        state_n = IDLE;
        ptr_n   = wrap_inc(cur_sel);
        cnt_n   = '0;
      end else begin
        state_n = LOCKED;
        sel_n   = cur_sel;
        if (xfer) cnt_n = sat_inc(cnt_p0);
      end
      if (xfer && !dii.debug_out_last && (int'(cnt_p0) + 1 == MAX_PKT_LEN)) err_n = 1'b1;
    end
  end

  // Registered control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0        <= IDLE;
      sel_p0          <= '0;
      ptr_p0          <= '0;
      cnt_p0          <= '0;
      err_p0          <= 1'b0;
      grant_active_p0 <= 1'b0;
      grant_idx_p0    <= '0;
    end else begin
      state_p0        <= state_n;
      sel_p0          <= sel_n;
      ptr_p0          <= ptr_n;
      cnt_p0          <= cnt_n;
      err_p0          <= err_n;
      grant_active_p0 <= (state_n == LOCKED);
      grant_idx_p0    <= (state_n == LOCKED) ? sel_n : '0;
    end
  end

  assign grant_active = grant_active_p0;
  assign grant_idx    = grant_idx_p0;
  assign pkt_len_err  = err_p0;
endmodule

// File: tb/tb_osd_dii_arbiter.sv
// Scoreboard bench for osd_dii_arbiter (NUM_IN=2, MAX_PKT_LEN=12) driven by directed packets.
module tb_osd_dii_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       grant_active;
  logic [0:0] grant_idx;
  logic       pkt_len_err;

  osd_dii_arbiter_if #(.NUM_IN(2)) dii ();

  osd_dii_arbiter #(.NUM_IN(2), .MAX_PKT_LEN(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .dii          (dii.slave),
    .grant_active (grant_active),
    .grant_idx    (grant_idx),
    .pkt_len_err  (pkt_len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic        last;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [16:0] sq0[$];
  logic [16:0] sq1[$];
  logic [1:0]  en;
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_all();
    dii.debug_in_valid[0] = en[0] && (sq0.size() > 0);
    dii.debug_in_valid[1] = en[1] && (sq1.size() > 0);
    {dii.debug_in_last[0], dii.debug_in_data[0]} = (sq0.size() > 0) ? sq0[0] : 17'h0;
    {dii.debug_in_last[1], dii.debug_in_data[1]} = (sq1.size() > 0) ? sq1[0] : 17'h0;
  endtask

  task automatic add_flit(input logic src, input logic [15:0] data, input logic last,
                          input logic expect_out);
    exp_t e;
    if (src) sq1.push_back({last, data});
    else     sq0.push_back({last, data});
    if (expect_out) begin
      e.src  = src;
      e.last = last;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_pkt(input logic src, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) add_flit(src, base + 16'(k), (k == n - 1), 1'b1);
  endtask

  task automatic wait_drain(input string name, input int max);
    for (int c = 0; c < max && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  // Source model: pop a flit after every accepted transfer, then present the next one.
  initial begin
    logic p0, p1;
    forever begin
      @(negedge clk);
      p0 = dii.debug_in_valid[0] && dii.debug_in_ready[0];
      p1 = dii.debug_in_valid[1] && dii.debug_in_ready[1];
      @(posedge clk);
      #1;
      if (p0 && sq0.size() > 0) void'(sq0.pop_front());
      if (p1 && sq1.size() > 0) void'(sq1.pop_front());
      drive_all();
    end
  end

  // Monitor: every accepted output flit is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && dii.debug_out_valid && dii.debug_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", {15'h0, dii.debug_out_last, dii.debug_out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", dii.debug_out_data, e.data);
        chk("out_last", dii.debug_out_last, e.last);
        chk("grant_ready", dii.debug_in_ready, (2'b01 << e.src));
        n_out++;
      end
    end
  end

  initial begin
    int target;
    rst = 1'b1;
    en  = 2'b11;
    dii.debug_out_ready = 1'b1;
    // Reset with both sources requesting
    add_flit(1'b0, 16'h0001, 1'b1, 1'b1);
    add_flit(1'b1, 16'h1001, 1'b1, 1'b1);
    drive_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", dii.debug_out_valid, 0);
    chk("rst_in_ready", dii.debug_in_ready, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_len_err", pkt_len_err, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_drain("reset_release_drain", 20);

    // Round robin, single-flit packets, one flit per cycle
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) begin
      push_pkt(1'b0, 16'h0010 + 16'(k), 1);
      push_pkt(1'b1, 16'h1010 + 16'(k), 1);
    end
    drive_all();
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    chk("rr_rate_remaining", exp_q.size(), 0);

    // Atomic multi-flit packet while the other source waits
    @(posedge clk); #2;
    push_pkt(1'b0, 16'h000A, 3);
    push_pkt(1'b1, 16'h1020, 1);
    drive_all();
    @(posedge clk);
    @(negedge clk);
    chk("lock_active", grant_active, 1);
    chk("lock_idx", grant_idx, 0);
    wait_drain("atomic_drain", 20);

    // Backpressure: stalled flit of source 1 stays presented while source 0 arrives
    @(posedge clk); #2;
    dii.debug_out_ready = 1'b0;
    en = 2'b10;
    push_pkt(1'b1, 16'h1030, 1);
    push_pkt(1'b0, 16'h0030, 1);
    drive_all();
    @(posedge clk); #2;
    en = 2'b11;
    drive_all();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_active", grant_active, 1);
      chk("bp_idx", grant_idx, 1);
      chk("bp_data", dii.debug_out_data, 16'h1030);
      chk("bp_valid", dii.debug_out_valid, 1);
    end
    @(posedge clk); #2;
    dii.debug_out_ready = 1'b1;
    wait_drain("bp_drain", 20);

    // Length limit: exactly MAX_PKT_LEN flits is legal
    @(posedge clk); #2;
    push_pkt(1'b0, 16'h0100, 12);
    drive_all();
    wait_drain("len12_drain", 40);
    chk("len12_err", pkt_len_err, 0);

    // One flit too many: error rises with the 12th non-last flit and stays
    @(posedge clk); #2;
    target = n_out + 12;
    push_pkt(1'b0, 16'h0200, 13);
    drive_all();
    for (int c = 0; c < 40 && n_out < target; c++) begin
      @(negedge clk); #1;
    end
    chk("len13_reached", n_out, target);
    chk("len13_err_before", pkt_len_err, 0);
    @(negedge clk); #1;
    chk("len13_err_after", pkt_len_err, 1);
    wait_drain("len13_drain", 40);
    chk("len13_err_sticky", pkt_len_err, 1);

    // Reset in the middle of a 4-flit packet from source 1
    @(posedge clk); #2;
    add_flit(1'b1, 16'h1040, 1'b0, 1'b1);
    add_flit(1'b1, 16'h1041, 1'b0, 1'b0);
    add_flit(1'b1, 16'h1042, 1'b0, 1'b0);
    add_flit(1'b1, 16'h1043, 1'b1, 1'b0);
    drive_all();
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_out_valid", dii.debug_out_valid, 0);
    chk("midrst_in_ready", dii.debug_in_ready, 0);
    @(posedge clk); #2;
    sq0.delete();
    sq1.delete();
    rst = 1'b0;
    drive_all();
    @(negedge clk);
    chk("midrst_active", grant_active, 0);
    chk("midrst_idx", grant_idx, 0);
    chk("midrst_err", pkt_len_err, 0);
    // Pointer back at 0: source 0 must win over source 1
    @(posedge clk); #2;
    push_pkt(1'b0, 16'h0050, 1);
    push_pkt(1'b1, 16'h1050, 1);
    drive_all();
    wait_drain("post_rst_drain", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
